// File: rtl/ppu_pkg.sv
// ppu_pkg: register indices, palette boundary and PPUCTRL/PPUMASK bit-field layouts.
package ppu_pkg;
    localparam logic [2:0] PPUCTRL_IDX   = 3'd0;
    localparam logic [2:0] PPUMASK_IDX   = 3'd1;
    localparam logic [2:0] PPUSTATUS_IDX = 3'd2;
    localparam logic [2:0] OAMADDR_IDX   = 3'd3;
    localparam logic [2:0] OAMDATA_IDX   = 3'd4;
    localparam logic [2:0] PPUSCROLL_IDX = 3'd5;
    localparam logic [2:0] PPUADDR_IDX   = 3'd6;
    localparam logic [2:0] PPUDATA_IDX   = 3'd7;
    localparam logic [13:0] PALETTE_BASE = 14'h3F00;
    typedef struct packed {
        logic       nmi_en;
        logic       slave;
        logic       spr_size;
        logic       bg_pt;
        logic       spr_pt;
        logic       inc32;
        logic [1:0] nametable;
    } ppu_ctrl_t;
    typedef struct packed {
        logic emph_b;
        logic emph_g;
        logic emph_r;
        logic show_spr;
        logic show_bg;
        logic show_spr_left;
        logic show_bg_left;
        logic greyscale;
    } ppu_mask_t;
endpackage

// File: rtl/ppu_reg_file_loopy.sv
// ppu_loopy_regs: loopy t/v/x/w scroll state, $2000/$2005/$2006 updates and the PPUDATA v increment.
module ppu_loopy_regs
    import ppu_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        wr,
    input  logic        status_rd,
    input  logic        inc,
    input  logic        inc32,
    input  logic [2:0]  idx,
    input  logic [7:0]  d,
    output logic [14:0] t,
    output logic [14:0] v,
    output logic [2:0]  x,
    output logic        w
);
    always_ff @(posedge clk or posedge rst)
        if (rst) begin
            t <= '0;
            v <= '0;
            x <= '0;
            w <= 1'b0;
        end else begin
            if (status_rd) w <= 1'b0;
            if (inc) v <= v + (inc32 ? 15'd32 : 15'd1);
            if (wr)
                case (idx)
                    PPUCTRL_IDX: t[11:10] <= d[1:0];
                    PPUSCROLL_IDX: begin
                        if (!w) begin
                            x      <= d[2:0];
                            t[4:0] <= d[7:3];
                        end else begin
                            t[14:12] <= d[2:0];
                            t[9:5]   <= d[7:3];
                        end
                        w <= !w;
                    end
                    PPUADDR_IDX: begin
                        if (!w) t[14:8] <= {1'b0, d[5:0]};
                        else begin
                            t[7:0] <= d;
                            v      <= {t[14:8], d};
                        end
                        w <= !w;
                    end
                    default: ;
                endcase
        end
endmodule

// File: rtl/ppu_reg_file.sv
// ppu_reg_file: PPU responder for the CPU $2000-$3FFF window (decode, flags, read buffer, OAM, DMA).
// Define PPU_OPEN_BUS_EN to add the io_latch that feeds write-only and unused PPUSTATUS read bits.
module ppu_reg_file #(
    parameter int          VRAM_ADDR_W  = 14,
    parameter logic [13:0] PALETTE_BASE = ppu_pkg::PALETTE_BASE
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   cs_n,
    input  logic [2:0]             reg_addr,
    input  logic                   WE,
    input  logic [7:0]             data_in,
    output logic [7:0]             data_out,
    input  logic                   oam_dma,
    input  logic [7:0]             dma_index,
    input  logic [7:0]             dma_data,
    output logic [7:0]             ppuctrl,
    output logic [7:0]             ppumask,
    output logic [VRAM_ADDR_W-1:0] vram_addr,
    output logic                   vram_we,
    output logic [7:0]             vram_wdata,
    input  logic [7:0]             vram_rdata,
    output logic [7:0]             oam_addr,
    output logic                   oam_we,
    output logic [7:0]             oam_wdata,
    input  logic [7:0]             oam_rdata,
    input  logic                   vblank_set,
    input  logic                   vblank_clr,
    input  logic                   sprite0_hit,
    input  logic                   sprite_ovf,
    output logic [2:0]             fine_x,
    output logic [14:0]            loopy_t,
    output logic [14:0]            loopy_v,
    output logic                   nmi
);
    import ppu_pkg::*;
    ppu_ctrl_t  ctrl;
    ppu_mask_t  mask;
    logic [7:0] oam_ptr, rd_buf, prev_idx, open_bus;
    logic [2:0] prev_addr;
    logic       prev_cs_n, prev_we, prev_dma, vblank_flag, w;
    logic       start, wr, rd, status_rd, dma_wr;
    // An access starts once; holding cs_n with the same index and direction is inert.
    assign start     = !reset && !cs_n && (prev_cs_n || prev_addr != reg_addr || prev_we != WE);
    assign wr        = start && WE;
    assign rd        = start && !WE;
    assign status_rd = rd && reg_addr == PPUSTATUS_IDX;
    assign dma_wr    = !reset && oam_dma && (!prev_dma || dma_index != prev_idx);
    assign vram_we    = wr && reg_addr == PPUDATA_IDX;
    assign vram_wdata = data_in;
    assign vram_addr  = loopy_v[VRAM_ADDR_W-1:0];
    assign oam_we     = dma_wr || (wr && reg_addr == OAMDATA_IDX && !oam_dma);
    assign oam_wdata  = oam_dma ? dma_data : data_in;
    assign oam_addr   = oam_dma ? oam_ptr + dma_index : oam_ptr;
    assign ppuctrl    = ctrl;
    assign ppumask    = mask;
    assign nmi        = ctrl.nmi_en && vblank_flag;
`ifdef PPU_OPEN_BUS_EN
    logic [7:0] io_latch;
    always_ff @(posedge clk or posedge reset)
        if (reset) io_latch <= '0;
        else io_latch <= wr ? data_in : rd ? data_out : io_latch;
    assign open_bus = io_latch;
`else
    assign open_bus = 8'h00;
`endif
    assign data_out = (cs_n || WE) ? 8'h00 :
                      reg_addr == PPUSTATUS_IDX ? {vblank_flag, sprite0_hit, sprite_ovf, open_bus[4:0]} :
                      reg_addr == OAMDATA_IDX ? oam_rdata :
                      reg_addr == PPUDATA_IDX ? (loopy_v[13:0] >= PALETTE_BASE ? vram_rdata : rd_buf) :
                      open_bus;
    always_ff @(posedge clk or posedge reset)
        if (reset) begin
            prev_cs_n   <= 1'b1;
            prev_addr   <= '0;
            prev_we     <= 1'b0;
            prev_dma    <= 1'b0;
            prev_idx    <= '0;
            ctrl        <= '0;
            mask        <= '0;
            oam_ptr     <= '0;
            rd_buf      <= '0;
            vblank_flag <= 1'b0;
        end else begin
            prev_cs_n <= cs_n;
            prev_addr <= reg_addr;
            prev_we   <= WE;
            prev_dma  <= oam_dma;
            prev_idx  <= dma_index;
            if (wr && reg_addr == PPUCTRL_IDX) ctrl <= ppu_ctrl_t'(data_in);
            if (wr && reg_addr == PPUMASK_IDX) mask <= ppu_mask_t'(data_in);
            if (wr && reg_addr == OAMADDR_IDX) oam_ptr <= data_in;
            else if (wr && reg_addr == OAMDATA_IDX && !oam_dma) oam_ptr <= oam_ptr + 8'd1;
            if (rd && reg_addr == PPUDATA_IDX) rd_buf <= vram_rdata;
            vblank_flag <= vblank_clr ? 1'b0 : vblank_set ? 1'b1 : status_rd ? 1'b0 : vblank_flag;
        end
    ppu_loopy_regs u_loopy (
        .clk       (clk),
        .rst       (reset),
        .wr        (wr),
        .status_rd (status_rd),
        .inc       (start && reg_addr == PPUDATA_IDX),
        .inc32     (ctrl.inc32),
        .idx       (reg_addr),
        .d         (data_in),
        .t         (loopy_t),
        .v         (loopy_v),
        .x         (fine_x),
        .w         (w)
    );
endmodule

// File: tb/tb_ppu_reg_file.sv
// tb_ppu_reg_file: directed register-window, scroll, status, OAM and DMA vectors for ppu_reg_file.
module tb_ppu_reg_file;
    logic        clk = 1'b0, rst = 1'b1, cs_n = 1'b1, we = 1'b0, oam_dma = 1'b0;
    logic [2:0]  reg_addr = '0;
    logic [7:0]  data_in = '0, dma_index = '0, dma_data = '0, vram_rdata = '0, oam_rdata = '0;
    logic        vblank_set = 1'b0, vblank_clr = 1'b0, sprite0_hit = 1'b0, sprite_ovf = 1'b0;
    logic [7:0]  data_out, ppuctrl, ppumask, oam_addr, oam_wdata, vram_wdata;
    logic [13:0] vram_addr;
    logic        vram_we, oam_we, nmi;
    logic [2:0]  fine_x;
    logic [14:0] loopy_t, loopy_v;
    int          vectors = 0, errors = 0, pulses = 0, bad = 0;

    ppu_reg_file dut (
        .clk(clk), .reset(rst), .cs_n(cs_n), .reg_addr(reg_addr), .WE(we),
        .data_in(data_in), .data_out(data_out), .oam_dma(oam_dma), .dma_index(dma_index),
        .dma_data(dma_data), .ppuctrl(ppuctrl), .ppumask(ppumask), .vram_addr(vram_addr),
        .vram_we(vram_we), .vram_wdata(vram_wdata), .vram_rdata(vram_rdata), .oam_addr(oam_addr),
        .oam_we(oam_we), .oam_wdata(oam_wdata), .oam_rdata(oam_rdata), .vblank_set(vblank_set),
        .vblank_clr(vblank_clr), .sprite0_hit(sprite0_hit), .sprite_ovf(sprite_ovf),
        .fine_x(fine_x), .loopy_t(loopy_t), .loopy_v(loopy_v), .nmi(nmi)
    );

    always #5 clk = !clk;

    task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        vectors++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic acc(input logic [2:0] a, input logic w_i, input logic [7:0] d);
        cs_n = 1'b0;
        reg_addr = a;
        we = w_i;
        data_in = d;
    endtask

    task automatic idle();
        cs_n = 1'b1;
        we = 1'b0;
    endtask

    task automatic wr(input logic [2:0] a, input logic [7:0] d);
        acc(a, 1'b1, d);
        tick();
        idle();
        tick();
    endtask

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not reach the summary");
        $fatal(1);
    end

    initial begin
        tick();
        tick();
        check("rst_v", 16'(loopy_v), 16'h0000);
        check("rst_ctrl", 16'(ppuctrl), 16'h0000);
        check("rst_oam_addr", 16'(oam_addr), 16'h0000);
        check("rst_strobes", {14'd0, vram_we, oam_we}, 16'h0000);
        rst = 1'b0;
        tick();
        // PPUADDR pair then PPUDATA write at +1 and +32
        wr(3'd6, 8'h21);
        wr(3'd6, 8'h08);
        check("addr_v", 16'(loopy_v), 16'h2108);
        acc(3'd7, 1'b1, 8'hAA);
        #1;
        check("data_we", {7'd0, vram_we, vram_wdata}, 16'h01AA);
        check("data_addr", 16'(vram_addr), 16'h2108);
        tick();
        check("data_v_inc1", 16'(loopy_v), 16'h2109);
        check("data_hold_we", 16'(vram_we), 16'h0000);
        tick();
        check("data_hold_v", 16'(loopy_v), 16'h2109);
        idle();
        tick();
        wr(3'd0, 8'h04);
        wr(3'd7, 8'hBB);
        check("data_v_inc32", 16'(loopy_v), 16'h2129);
        // read buffer vs palette bypass
        wr(3'd0, 8'h00);
        wr(3'd6, 8'h20);
        wr(3'd6, 8'h00);
        vram_rdata = 8'h55;
        acc(3'd7, 1'b0, 8'h00);
        #1;
        check("rd_buf_first", 16'(data_out), 16'h0000);
        tick();
        idle();
        tick();
        check("rd_v_inc", 16'(loopy_v), 16'h2001);
        acc(3'd7, 1'b0, 8'h00);
        #1;
        check("rd_buf_second", 16'(data_out), 16'h0055);
        tick();
        idle();
        tick();
        wr(3'd6, 8'h3F);
        wr(3'd6, 8'h01);
        vram_rdata = 8'h0F;
        acc(3'd7, 1'b0, 8'h00);
        #1;
        check("rd_palette", 16'(data_out), 16'h000F);
        tick();
        idle();
        tick();
        // scroll writes
        wr(3'd0, 8'h00);
        wr(3'd5, 8'h7D);
        wr(3'd5, 8'h5E);
        check("scroll_x", 16'(fine_x), 16'h0005);
        check("scroll_t", 16'(loopy_t), 16'h616F);
        // vblank, nmi and PPUSTATUS side effects
        wr(3'd0, 8'h80);
        vblank_set = 1'b1;
        tick();
        vblank_set = 1'b0;
        check("nmi_set", 16'(nmi), 16'h0001);
        wr(3'd6, 8'h12);
        acc(3'd2, 1'b0, 8'h00);
        #1;
        check("status_rd", 16'(data_out), 16'h0080);
        tick();
        check("status_nmi_clr", 16'(nmi), 16'h0000);
        vblank_set = 1'b1;
        tick();
        vblank_set = 1'b0;
        tick();
        tick();
        check("status_hold_once", 16'(nmi), 16'h0001);
        idle();
        tick();
        wr(3'd6, 8'h12);
        wr(3'd6, 8'h34);
        check("status_w_clr", 16'(loopy_v), 16'h1234);
        vblank_clr = 1'b1;
        tick();
        vblank_clr = 1'b0;
        check("vblank_clr", 16'(nmi), 16'h0000);
        sprite0_hit = 1'b1;
        acc(3'd2, 1'b0, 8'h00);
        #1;
        check("status_spr0", 16'(data_out), 16'h0040);
        tick();
        idle();
        sprite0_hit = 1'b0;
        tick();
        acc(3'd2, 1'b0, 8'h00);
        vblank_set = 1'b1;
        #1;
        check("set_wins_rd", 16'(data_out), 16'h0000);
        tick();
        vblank_set = 1'b0;
        idle();
        check("set_wins_flag", 16'(nmi), 16'h0001);
        vblank_set = 1'b1;
        vblank_clr = 1'b1;
        tick();
        vblank_set = 1'b0;
        vblank_clr = 1'b0;
        check("clr_wins", 16'(nmi), 16'h0000);
        // OAMADDR / OAMDATA
        wr(3'd3, 8'hFF);
        acc(3'd4, 1'b1, 8'hAB);
        #1;
        check("oam_we", {7'd0, oam_we, oam_wdata}, 16'h01AB);
        check("oam_we_addr", 16'(oam_addr), 16'h00FF);
        tick();
        idle();
        tick();
        check("oam_wrap", 16'(oam_addr), 16'h0000);
        wr(3'd3, 8'h10);
        oam_rdata = 8'h5A;
        acc(3'd4, 1'b0, 8'h00);
        #1;
        check("oam_rd", 16'(data_out), 16'h005A);
        tick();
        idle();
        tick();
        check("oam_rd_noinc", 16'(oam_addr), 16'h0010);
        // OAM DMA, each index held two cycles
        oam_dma = 1'b1;
        for (int i = 0; i < 256; i++)
            for (int c = 0; c < 2; c++) begin
                dma_index = i[7:0];
                dma_data = i[7:0] ^ 8'hC3;
                #1;
                if (oam_we) begin
                    pulses++;
                    if (oam_addr !== 8'(16 + i) || oam_wdata !== (i[7:0] ^ 8'hC3)) bad++;
                end
                tick();
            end
        check("dma_pulses", 16'(pulses), 16'd256);
        check("dma_addr_data", 16'(bad), 16'd0);
        acc(3'd4, 1'b1, 8'hEE);
        #1;
        check("dma_cpu_drop", 16'(oam_we), 16'h0000);
        tick();
        idle();
        tick();
        oam_dma = 1'b0;
        #1;
        check("dma_oam_addr", 16'(oam_addr), 16'h0010);
        tick();
        // reset in the middle of the second PPUADDR write
        wr(3'd6, 8'h21);
        acc(3'd6, 1'b1, 8'h08);
        #1;
        rst = 1'b1;
        #1;
        check("rst_mid_v", 16'(loopy_v), 16'h0000);
        check("rst_mid_t", 16'(loopy_t), 16'h0000);
        check("rst_mid_we", {14'd0, vram_we, oam_we}, 16'h0000);
        tick();
        rst = 1'b0;
        tick();
        check("rst_first_write", 16'(loopy_t), 16'h0800);
        check("rst_first_v", 16'(loopy_v), 16'h0000);
        idle();
        tick();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end
endmodule

// File: doc/ppu_reg_file.md
Name: ppu_reg_file

Overview:
- PPU-side responder for the CPU's $2000-$3FFF register window, which is mirrored every 8 bytes.
- Decodes the active-low chip select, 3-bit register index and write enable driven by the CPU memory mapper.
- Holds PPUCTRL, PPUMASK, OAMADDR and the loopy t/v/x/w scroll state, plus the PPUDATA read buffer.
- Drives VRAM and OAM port strobes, and accepts the OAM DMA byte stream from the mapper.

Parameters:
- VRAM_ADDR_W, 14, width of the vram_addr output.
- PALETTE_BASE, 14'h3F00, addresses at or above this bypass the PPUDATA read buffer.

Ports:
- clk  in  1  system clock.
- reset  in  1  asynchronous, active-high reset.
- cs_n  in  1  register select, low = access (the mapper's ppu_reg_cs).
- reg_addr  in  3  register index 0-7.
- WE  in  1  write enable; a low level with cs_n low is a read.
- data_in  in  8  CPU write data.
- data_out  out  8  CPU read data; combinational, valid during the access.
- oam_dma  in  1  high while an OAM DMA is in progress.
- dma_index  in  8  DMA byte index, 0-255; each value is held 2 cycles.
- dma_data  in  8  DMA byte, valid while oam_dma is high.
- ppuctrl  out  8  PPUCTRL value.
- ppumask  out  8  PPUMASK value.
- vram_addr  out  VRAM_ADDR_W  equals v[13:0].
- vram_we  out  1  one-cycle VRAM write strobe.
- vram_wdata  out  8  VRAM write data.
- vram_rdata  in  8  VRAM data at vram_addr; combinational.
- oam_addr  out  8  OAM address.
- oam_we  out  1  one-cycle OAM write strobe.
- oam_wdata  out  8  OAM write data.
- oam_rdata  in  8  OAM data at oam_addr.
- vblank_set  in  1  pulse at the start of vblank (scanline 241).
- vblank_clr  in  1  pulse at the pre-render line.
- sprite0_hit  in  1  live status flag.
- sprite_ovf  in  1  live status flag.
- fine_x  out  3  x register.
- loopy_t  out  15  t register.
- loopy_v  out  15  v register.
- nmi  out  1  equals ppuctrl[7] AND vblank_flag, level.

Behaviour:
- Reset: all registers and outputs are 0, including t, v, x, w, the read buffer, vblank_flag, strobes and nmi.
- Access start:
  - Defined as cs_n low in a cycle where the previous cycle had cs_n high, or a different reg_addr, or a different WE.
  - All side effects happen exactly once, at the clock edge ending the start cycle.
  - Held cycles produce no further effects. data_out stays combinational throughout.
- Writes:
  - 0 PPUCTRL: ctrl <= d; t[11:10] <= d[1:0].
  - 1 PPUMASK: mask <= d.
  - 2 PPUSTATUS: ignored.
  - 3 OAMADDR: oam_addr <= d.
  - 4 OAMDATA: oam_we = 1 for one cycle; oam_wdata = d at the current oam_addr; then oam_addr increments, wrapping 255 -> 0.
  - 5 PPUSCROLL, w=0: x <= d[2:0]; t[4:0] <= d[7:3]; w <= 1.
  - 5 PPUSCROLL, w=1: t[14:12] <= d[2:0]; t[9:5] <= d[7:3]; w <= 0.
  - 6 PPUADDR, w=0: t[13:8] <= d[5:0]; t[14] <= 0; w <= 1.
  - 6 PPUADDR, w=1: t[7:0] <= d; v <= {t[14:8], d}; w <= 0.
  - 7 PPUDATA: vram_we = 1 for one cycle, vram_wdata = d.
- Reads (data_out):
  - 2: {vblank_flag, sprite0_hit, sprite_ovf, 5'b0}. Side effect: vblank_flag <= 0, w <= 0.
  - 4: oam_rdata; no increment.
  - 7, v[13:0] < PALETTE_BASE: returns the buffer; buffer <= vram_rdata.
  - 7, v[13:0] >= PALETTE_BASE: returns vram_rdata; buffer <= vram_rdata.
  - 0, 1, 3, 5, 6: 8'h00 (see the optional feature).
- PPUDATA read or write: v <= v + (ctrl[2] ? 32 : 1), taken modulo 2^15.
- vblank_flag:
  - Set by vblank_set; cleared by vblank_clr or a PPUSTATUS read.
  - vblank_set in the same cycle as a PPUSTATUS read: the read returns bit7 = 0 and the flag ends up 1 (set wins).
  - vblank_set and vblank_clr together: clear wins.
- nmi is combinational, so writing ctrl[7]=1 while vblank_flag=1 raises nmi the next cycle.
- OAM DMA:
  - A DMA write occurs on the first cycle oam_dma is high and on every cycle dma_index differs from its registered previous value.
  - Each DMA write drives oam_we = 1, oam_wdata = dma_data, at address oam_addr + dma_index (8-bit wrap).
  - oam_addr itself is not modified by DMA.
  - While oam_dma is high, CPU OAMDATA writes are dropped; all other register accesses behave normally.
- Reset mid-access or mid-DMA: state clears immediately and strobes drop. A still-low cs_n is treated as a new access start after reset deasserts.

Optional Feature:
- Macro PPU_OPEN_BUS_EN.
- Defined: an 8-bit io_latch is loaded with every written byte and every returned read byte.
  - Write-only register reads return io_latch.
  - PPUSTATUS bits [4:0] return io_latch[4:0].
- Undefined: those bits and registers read as 0 and no latch exists.

Decomposition:
- Shared package ppu_pkg holds the register index constants (PPUCTRL_IDX ... PPUDATA_IDX), PALETTE_BASE, and packed structs for the ctrl/mask bit fields.
- One sub-module, ppu_loopy_regs, owns t/v/x/w updates and the v increment; the top handles decode, flags, buffer and OAM.

Test Plan:
- Write $2006=8'h21, then 8'h08 -> v=15'h2108, w=0. PPUDATA write 8'hAA -> vram_we pulse at 14'h2108, v=15'h2109. Repeat with ctrl[2]=1 -> v increments by 32.
- v=15'h2000, vram_rdata=8'h55 -> first $2007 read returns 0, second read returns 8'h55. With v=15'h3F01, vram_rdata=8'h0F -> read returns 8'h0F directly.
- vblank_set pulse with ctrl=8'h80 -> nmi=1. $2002 read returns 8'h80 -> nmi=0 and w=0. Hold cs_n low 4 cycles -> flag cleared once, w cleared once.
- $2005 writes 8'h7D, 8'h5E -> x=3'b101, t=15'h616F.
- OAMADDR=8'h10; DMA with dma_index 0..255, each held 2 cycles -> exactly 256 oam_we pulses at addresses 8'h10..8'h0F (wrapping); oam_addr remains 8'h10.
- Assert reset during the second of two PPUADDR writes -> v=0, t=0, w=0, no vram_we, and the next access is treated as a first write.
